// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured parallel pattern out MSB-first on X,
// repeating it a captured number of times with an optional idle gap, then pulses done.
module serial_pattern_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned REP_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW       = $clog2(WIDTH);
  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             x_d, xv_d, busy_d, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // rep_q counts repetitions still to send, including the one in progress;
  // bit_q is the index of the bit currently on X.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (reps != '0)) begin
          state_d = SHIFT;
          pat_d   = pattern;
          rep_d   = reps;
          bit_d   = BW'(WIDTH - 1);
          x_d     = pattern[WIDTH-1];
          xv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_q != '0) begin
          bit_d  = bit_q - BW'(1);
          x_d    = pat_q[bit_d];
          xv_d   = 1'b1;
          busy_d = 1'b1;
        end else if (rep_q > REP_W'(1)) begin
          rep_d  = rep_q - REP_W'(1);
          busy_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GW'(GAP_LAST);
          end else begin
            bit_d = BW'(WIDTH - 1);
            x_d   = pat_q[WIDTH-1];
            xv_d  = 1'b1;
          end
        end else begin
          state_d = DONE;
          rep_d   = '0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else begin
            state_d = SHIFT;
            bit_d   = BW'(WIDTH - 1);
            x_d     = pat_q[WIDTH-1];
            xv_d    = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      X       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      X       <= x_d;
      x_valid <= xv_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: per-cycle expected outputs queued from a spec model,
// checked one entry per clock against a gapped (2) and a back-to-back (0) instance.
module tb_serial_pattern_tx;

  typedef struct packed {
    logic x;
    logic xv;
    logic busy;
    logic done;
  } out_t;

  typedef struct {
    logic [7:0] pattern;
    logic [3:0] reps;
    bit         nogap;
    int         exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] reps = '0;
  logic       x_a, xv_a, busy_a, done_a;
  logic       x_b, xv_b, busy_b, done_b;

  bit    sel = 1'b0;
  int    checks = 0;
  int    errors = 0;
  string tag = "";
  out_t  q[$];
  out_t  cur;
  vec_t  vecs[7];

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2), .REP_W(4)) dut_gap (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort), .pattern(pattern),
    .reps(reps), .X(x_a), .x_valid(xv_a), .busy(busy_a), .done(done_a));

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .REP_W(4)) dut_nogap (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort), .pattern(pattern),
    .reps(reps), .X(x_b), .x_valid(xv_b), .busy(busy_b), .done(done_b));

  function automatic out_t mk(input logic x, input logic v, input logic b, input logic d);
    out_t o;
    o.x = x; o.xv = v; o.busy = b; o.done = d;
    return o;
  endfunction

  function automatic out_t obs();
    return sel ? mk(x_b, xv_b, busy_b, done_b) : mk(x_a, xv_a, busy_a, done_a);
  endfunction

  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0b v=%0b busy=%0b done=%0b, required x=%0b v=%0b busy=%0b done=%0b",
               name, got.x, got.xv, got.busy, got.done, exp.x, exp.xv, exp.busy, exp.done);
    end
  endtask

  // Expected stream from an accepted start: bits, gaps, done pulse, then idle.
  task automatic push_run(input logic [7:0] p, input int r, input int g);
    for (int i = 0; i < r; i++) begin
      for (int k = 7; k >= 0; k--) q.push_back(mk(p[k], 1'b1, 1'b1, 1'b0));
      if (i != r - 1)
        for (int j = 0; j < g; j++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic step();
    out_t e;
    @(posedge clk);
    #1;
    cur = obs();
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(tag, cur, e);
    end
  endtask

  task automatic run_start(input logic [7:0] p, input logic [3:0] r, input bit ng,
                           input int exp_done, input string name);
    int n;
    int done_at;
    tag = name;
    sel = ng;
    pattern = p;
    reps = r;
    push_run(p, int'(r), ng ? 0 : 2);
    if (ng) start_b = 1'b1;
    else    start_a = 1'b1;
    step();
    n = 1;
    done_at = cur.done ? 1 : -1;
    start_a = 1'b0;
    start_b = 1'b0;
    abort = 1'b0;
    while (q.size() > 0 && n < 400) begin
      step();
      n++;
      if (cur.done && done_at < 0) done_at = n;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d expected cycles left unchecked, required 0", name, q.size());
      q.delete();
    end
    checks++;
    if (done_at != exp_done) begin
      errors++;
      $display("FAIL %s_latency: done at step %0d, required %0d", name, done_at, exp_done);
    end
  endtask

  initial begin
    vecs[0] = '{8'hB2, 4'd1,  1'b0, 9};
    vecs[1] = '{8'hB2, 4'd2,  1'b0, 19};
    vecs[2] = '{8'hA5, 4'd3,  1'b1, 25};
    vecs[3] = '{8'h3C, 4'd15, 1'b0, 149};
    vecs[4] = '{8'h01, 4'd2,  1'b0, 19};
    vecs[5] = '{8'h81, 4'd1,  1'b1, 9};
    vecs[6] = '{8'h5A, 4'd15, 1'b1, 121};

    #1 reset = 1'b0;
    #1;
    sel = 1'b0;
    chk("reset_gap", obs(), mk(1'b0, 1'b0, 1'b0, 1'b0));
    sel = 1'b1;
    chk("reset_nogap", obs(), mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 7; i++)
      run_start(vecs[i].pattern, vecs[i].reps, vecs[i].nogap, vecs[i].exp_done,
                $sformatf("vec%0d", i));

    // Starts while busy and while in DONE must both be ignored.
    tag = "start_busy";
    sel = 1'b0;
    push_run(8'h0F, 1, 2);
    pattern = 8'h0F; reps = 4'd1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step();
    start_a = 1'b1; pattern = 8'hFF; reps = 4'd3;
    step();
    start_a = 1'b0;
    repeat (5) step();
    start_a = 1'b1; pattern = 8'hFF; reps = 4'd1;
    step();
    start_a = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();

    // Abort mid-shift, then a clean restart two cycles later.
    tag = "abort_shift";
    pattern = 8'hB2; reps = 4'd1;
    for (int k = 7; k >= 5; k--) q.push_back(mk(pattern[k], 1'b1, 1'b1, 1'b0));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step();
    abort = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();
    abort = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();
    run_start(8'h5A, 4'd1, 1'b0, 9, "restart_after_abort");

    // Abort during the inter-repetition gap.
    tag = "abort_gap";
    pattern = 8'hC3; reps = 4'd2;
    for (int k = 7; k >= 0; k--) q.push_back(mk(pattern[k], 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (8) step();
    abort = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();
    abort = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();

    // Abort together with start in IDLE has no effect.
    abort = 1'b1;
    run_start(8'h96, 4'd1, 1'b0, 9, "abort_idle");

    // Asynchronous reset between edges, then a zero-repeat start.
    tag = "reset_mid";
    sel = 1'b0;
    pattern = 8'hB2; reps = 4'd1;
    for (int k = 7; k >= 5; k--) q.push_back(mk(pattern[k], 1'b1, 1'b1, 1'b0));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk("async_reset", obs(), mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("reset_hold", obs(), mk(1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    tag = "reps_zero";
    start_a = 1'b1; reps = 4'd0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();
    start_a = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
